// File: rtl/instr_stream_encoder_pkg.sv
// Shared encodings for the instruction stream encoder: field widths, opcodes,
// request kinds, FSM states and the request payload struct.
package instr_stream_encoder_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned TARGET_W = 26;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned KIND_W   = 3;

  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_SRL   = 6'b000001;

  typedef enum logic [KIND_W-1:0] {
    KIND_LW  = 3'd0,
    KIND_SW  = 3'd1,
    KIND_LUI = 3'd2,
    KIND_J   = 3'd3,
    KIND_MUL = 3'd4,
    KIND_SRL = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [KIND_W-1:0]   kind;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    shamt;
    logic [IMM_W-1:0]    imm;
    logic [TARGET_W-1:0] target;
  } instr_fields_t;

  // Kinds 6 and 7 have no encoding in the decoder's accepted set.
  function automatic logic kind_is_legal(input logic [KIND_W-1:0] kind);
    return kind <= KIND_W'(KIND_SRL);
  endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Request handshake and instruction-memory write bus of the encoder.
interface instr_stream_encoder_if
  import instr_stream_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) ();

  logic                in_valid;
  logic                in_ready;
  logic [KIND_W-1:0]   in_kind;
  logic [REG_W-1:0]    in_rs;
  logic [REG_W-1:0]    in_rt;
  logic [REG_W-1:0]    in_rd;
  logic [REG_W-1:0]    in_shamt;
  logic [IMM_W-1:0]    in_imm;
  logic [TARGET_W-1:0] in_target;
  logic                in_last;

  logic                imem_we;
  logic [ADDR_W-1:0]   imem_addr;
  logic [WORD_W-1:0]   imem_wdata;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    input  in_ready,
    input  imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    output in_ready,
    output imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/instr_stream_encoder_field_pack.sv
// Combinational packer: request kind + fields -> 32-bit instruction word and
// an illegal-kind flag. Illegal kinds yield an all-zero word.
module instr_stream_encoder_field_pack
  import instr_stream_encoder_pkg::*;
#(
  parameter logic [FUNCT_W-1:0] FUNCT_MUL = 6'b011000
) (
  input  instr_fields_t       fields_i,
  output logic [WORD_W-1:0]   word_c,
  output logic                illegal_c
);

  always_comb begin
    word_c    = '0;
    illegal_c = !kind_is_legal(fields_i.kind);
    case (fields_i.kind)
      KIND_LW:  word_c = {OP_LW,  fields_i.rs, fields_i.rt, fields_i.imm};
      KIND_SW:  word_c = {OP_SW,  fields_i.rs, fields_i.rt, fields_i.imm};
      KIND_LUI: word_c = {OP_LUI, REG_W'(0),   fields_i.rt, fields_i.imm};
      KIND_J:   word_c = {OP_J,   fields_i.target};
      KIND_MUL: word_c = {OP_RTYPE, fields_i.rs, fields_i.rt, fields_i.rd,
                          REG_W'(0), FUNCT_MUL};
      KIND_SRL: word_c = {OP_SRL, fields_i.rs, fields_i.rt, REG_W'(0),
                          fields_i.shamt, FUNCT_W'(0)};
      default:  word_c = '0;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program loader: encodes accepted instruction requests and writes them to
// consecutive instruction-memory words, one write per accepted legal request.
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 10,
  parameter int unsigned        DEPTH     = 256,
  parameter logic [FUNCT_W-1:0] FUNCT_MUL = 6'b011000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  instr_stream_encoder_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal,
  output logic                  err_overflow,
  output logic [ADDR_W-1:0]     count
);

  state_e              state_q,        state_d;
  logic                in_ready_q,     in_ready_d;
  logic                busy_q,         busy_d;
  logic                done_q,         done_d;
  logic                imem_we_q,      imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q,    imem_addr_d;
  logic [WORD_W-1:0]   imem_wdata_q,   imem_wdata_d;
  logic [ADDR_W-1:0]   wr_addr_q,      wr_addr_d;
  logic [ADDR_W-1:0]   wr_cnt_q,       wr_cnt_d;
  logic [ADDR_W-1:0]   count_q,        count_d;
  logic                err_illegal_q,  err_illegal_d;
  logic                err_overflow_q, err_overflow_d;

  instr_fields_t       req_fields;
  logic [WORD_W-1:0]   pack_word_c;
  logic                pack_illegal_c;
  logic                accept_c;
  logic [1:0]          unused_base_lsb;

  // Word alignment is forced, so the two low base bits carry no information.
  assign unused_base_lsb = base_addr[1:0];

  assign req_fields.kind   = bus.in_kind;
  assign req_fields.rs     = bus.in_rs;
  assign req_fields.rt     = bus.in_rt;
  assign req_fields.rd     = bus.in_rd;
  assign req_fields.shamt  = bus.in_shamt;
  assign req_fields.imm    = bus.in_imm;
  assign req_fields.target = bus.in_target;

  instr_stream_encoder_field_pack #(
    .FUNCT_MUL (FUNCT_MUL)
  ) u_field_pack (
    .fields_i  (req_fields),
    .word_c    (pack_word_c),
    .illegal_c (pack_illegal_c)
  );

  assign accept_c = bus.in_valid && in_ready_q;

  // wr_addr/wr_cnt track writes as they are issued; count follows the strobes.
  always_comb begin
    state_d        = state_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    wr_addr_d      = wr_addr_q;
    wr_cnt_d       = wr_cnt_q;
    count_d        = imem_we_q ? count_q + ADDR_W'(1) : count_q;
    err_illegal_d  = err_illegal_q;
    err_overflow_d = err_overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_LOAD;
          wr_addr_d      = {base_addr[ADDR_W-1:2], 2'b00};
          wr_cnt_d       = '0;
          count_d        = '0;
          err_illegal_d  = 1'b0;
          err_overflow_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          if (pack_illegal_c) begin
            err_illegal_d = 1'b1;
          end else if (wr_cnt_q == ADDR_W'(DEPTH)) begin
            err_overflow_d = 1'b1;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = wr_addr_q;
            imem_wdata_d = pack_word_c;
            wr_addr_d    = wr_addr_q + ADDR_W'(4);
            wr_cnt_d     = wr_cnt_q + ADDR_W'(1);
          end
          if (bus.in_last) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      wr_addr_q      <= '0;
      wr_cnt_q       <= '0;
      count_q        <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      wr_addr_q      <= wr_addr_d;
      wr_cnt_q       <= wr_cnt_d;
      count_q        <= count_d;
      err_illegal_q  <= err_illegal_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_illegal    = err_illegal_q;
  assign err_overflow   = err_overflow_q;
  assign count          = count_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: a scoreboard of expected imem writes,
// a second instance with DEPTH=4 driven in lockstep for the overflow bound.
module tb_instr_stream_encoder;
  import instr_stream_encoder_pkg::*;

  localparam int unsigned ADDR_W = 10;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic [2:0]        in_kind = '0;
  logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              in_last = 1'b0;

  logic              busy, done, err_illegal, err_overflow;
  logic [ADDR_W-1:0] count;
  logic              busy4, done4, err_illegal4, err_overflow4;
  logic [ADDR_W-1:0] count4;

  int                n_cmp = 0;
  int                n_bad = 0;
  exp_t              exp_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  bit                ovf_phase = 1'b0;
  int                w4 = 0;

  always #5 clk = ~clk;

  instr_stream_encoder_if #(.ADDR_W(ADDR_W)) if0 ();
  instr_stream_encoder_if #(.ADDR_W(ADDR_W)) if4 ();

  assign if0.in_valid  = in_valid;   assign if4.in_valid  = in_valid;
  assign if0.in_kind   = in_kind;    assign if4.in_kind   = in_kind;
  assign if0.in_rs     = in_rs;      assign if4.in_rs     = in_rs;
  assign if0.in_rt     = in_rt;      assign if4.in_rt     = in_rt;
  assign if0.in_rd     = in_rd;      assign if4.in_rd     = in_rd;
  assign if0.in_shamt  = in_shamt;   assign if4.in_shamt  = in_shamt;
  assign if0.in_imm    = in_imm;     assign if4.in_imm    = in_imm;
  assign if0.in_target = in_target;  assign if4.in_target = in_target;
  assign if0.in_last   = in_last;    assign if4.in_last   = in_last;

  instr_stream_encoder #(.ADDR_W(ADDR_W), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(if0),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_overflow(err_overflow),
    .count(count)
  );

  instr_stream_encoder #(.ADDR_W(ADDR_W), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(if4),
    .busy(busy4), .done(done4), .err_illegal(err_illegal4), .err_overflow(err_overflow4),
    .count(count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && if0.imem_we === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", 32'(if0.imem_addr), 32'(e.addr));
        chk("imem_wdata", if0.imem_wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (ovf_phase && if4.imem_we === 1'b1) w4++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_lw(input logic [4:0] rs, rt, input logic [15:0] imm);
    return {6'b100011, rs, rt, imm};
  endfunction

  task automatic send(input logic [2:0] kind, input logic [4:0] rs, rt, rd, shamt,
                      input logic [15:0] imm, input logic [25:0] target, input logic last,
                      input logic [31:0] exp_word, input logic writes);
    in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = shamt;
    in_imm = imm; in_target = target; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (if0.in_ready === 1'b1) break;
    end
    chk("in_ready", 32'(if0.in_ready), 32'd1);
    if (writes) begin
      exp_q.push_back('{addr: exp_addr, data: exp_word});
      exp_addr = exp_addr + ADDR_W'(4);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_session(input logic [ADDR_W-1:0] base);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = {base[ADDR_W-1:2], 2'b00};
  endtask

  task automatic wait_done();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk("done_pulse", 32'(done), 32'd1);
  endtask

  initial begin
    int dn;
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(if0.in_ready), 32'd0);
    chk("rst_imem_we", 32'(if0.imem_we), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err_illegal", 32'(err_illegal), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    rst_n = 1'b1;

    // Single LW: strobe one cycle after accept, done the cycle after that
    start_session(10'h040);
    send(3'd0, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0010, 26'd0, 1'b1, 32'h8C430010, 1'b1);
    @(negedge clk);
    chk("lw_strobe_latency", 32'(if0.imem_we), 32'd1);
    chk("lw_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("lw_done", 32'(done), 32'd1);
    chk("lw_single_strobe", 32'(if0.imem_we), 32'd0);
    chk("lw_count", 32'(count), 32'd1);
    @(negedge clk);
    chk("lw_done_one_cycle", 32'(done), 32'd0);
    chk("lw_idle", 32'(busy), 32'd0);

    // SW, LUI, J back to back, last on J
    start_session(10'h040);
    send(3'd1, 5'd1, 5'd5, 5'd0, 5'd0, 16'hFFFC, 26'd0, 1'b0, 32'hAC25FFFC, 1'b1);
    send(3'd2, 5'd0, 5'd4, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0, 32'h3C041234, 1'b1);
    send(3'd3, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h40, 1'b1, 32'h08000040, 1'b1);
    @(negedge clk);
    chk("b2b_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_count", 32'(count), 32'd3);

    // Illegal kind between two LWs
    start_session(10'h100);
    send(3'd0, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0001, 26'd0, 1'b0, enc_lw(5'd1, 5'd1, 16'h0001), 1'b1);
    send(3'd6, 5'd7, 5'd7, 5'd7, 5'd7, 16'hBEEF, 26'd0, 1'b0, 32'd0, 1'b0);
    send(3'd0, 5'd6, 5'd9, 5'd0, 5'd0, 16'h0ABC, 26'd0, 1'b1, enc_lw(5'd6, 5'd9, 16'h0ABC), 1'b1);
    wait_done();
    chk("ill_err_illegal", 32'(err_illegal), 32'd1);
    chk("ill_err_overflow", 32'(err_overflow), 32'd0);
    chk("ill_count", 32'(count), 32'd2);

    // MUL and SRL across the address wrap
    start_session(10'h3FC);
    send(3'd4, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'd0, 1'b0,
         {6'b000000, 5'd7, 5'd8, 5'd9, 5'd0, 6'b011000}, 1'b1);
    send(3'd5, 5'd10, 5'd11, 5'd0, 5'd31, 16'h0, 26'd0, 1'b1,
         {6'b000001, 5'd10, 5'd11, 5'd0, 5'd31, 6'b000000}, 1'b1);
    wait_done();
    chk("wrap_count", 32'(count), 32'd2);
    chk("wrap_err_illegal_cleared", 32'(err_illegal), 32'd0);

    // Unaligned base and a start pulse while busy
    start_session(10'h043);
    send(3'd0, 5'd3, 5'd4, 5'd0, 5'd0, 16'h7777, 26'd0, 1'b0, enc_lw(5'd3, 5'd4, 16'h7777), 1'b1);
    start = 1'b1;
    base_addr = 10'h300;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy_still_busy", 32'(busy), 32'd1);
    send(3'd0, 5'd5, 5'd6, 5'd0, 5'd0, 16'h8888, 26'd0, 1'b1, enc_lw(5'd5, 5'd6, 16'h8888), 1'b1);
    wait_done();

    // Overflow: six requests into the DEPTH=4 instance
    start_session(10'h000);
    w4 = 0;
    ovf_phase = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(3'd0, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(i * 3), 26'd0, 1'(i == 5),
           enc_lw(5'(i), 5'(i + 1), 16'(i * 3)), 1'b1);
    end
    wait_done();
    chk("ovf_done4", 32'(done4), 32'd1);
    ovf_phase = 1'b0;
    chk("ovf_writes4", 32'(w4), 32'd4);
    chk("ovf_count4", 32'(count4), 32'd4);
    chk("ovf_err_overflow4", 32'(err_overflow4), 32'd1);
    chk("ovf_err_overflow_full", 32'(err_overflow), 32'd0);
    chk("ovf_count_full", 32'(count), 32'd6);

    // Reset in the middle of a session
    start_session(10'h200);
    send(3'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0001, 26'd0, 1'b0, enc_lw(5'd1, 5'd2, 16'h0001), 1'b1);
    send(3'd0, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0002, 26'd0, 1'b0, enc_lw(5'd3, 5'd4, 16'h0002), 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_count_before", 32'(count), 32'd2);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_imem_we", 32'(if0.imem_we), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_in_ready", 32'(if0.in_ready), 32'd0);
    rst_n = 1'b1;
    dn = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("midrst_no_done", 32'(dn), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
